// File: rtl/eb_uart_pkg.sv
// Shared types and helpers for the UART transmit-side arbiter slice.
// Contents: arbiter state enum, UART byte width, index-width helper.
package eb_uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        GAP
    } arb_state_t;

    // Width needed to index n items; never narrower than one bit.
    function automatic int unsigned idw(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
// Ports:
//   req  - request vector
//   ptr  - highest-priority index for this pick
//   gnt  - one-hot winner (0 if no request)
//   idx  - binary index of the winner (0 if no request)
module rr_pick
    import eb_uart_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]       req,
    input  logic [idw(N)-1:0]  ptr,
    output logic [N-1:0]       gnt,
    output logic [idw(N)-1:0]  idx
);

    localparam int unsigned IW = idw(N);

    logic        found;
    int unsigned cand;

    // Scan N positions starting from ptr; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr) + k) % N;
            if (!found && req[IW'(cand)]) begin
                found              = 1'b1;
                gnt[IW'(cand)]     = 1'b1;
                idx                = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one UART_tx among NUM_REQ byte streams.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/data/last - per-requester byte stream (data packed 8 bits per requester)
//   req_ready           - per-requester accept (combinational, only in LOAD)
//   tx_data, trmt       - byte and one-clock start pulse to UART_tx
//   tx_done             - UART_tx done level; its rising edge completes a byte
//   grant               - one-hot current owner, 0 when idle
//   busy                - high outside IDLE
//   abort, abort_id     - one-clock pulse and owner index when a frame stalls out
module uart_tx_arbiter
    import eb_uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned GAP_CYC = 0,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [UART_BYTE_W-1:0]         tx_data,
    output logic                           trmt,
    input  logic                           tx_done,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic                           abort,
    output logic [idw(NUM_REQ)-1:0]        abort_id
);

    localparam int unsigned IW    = idw(NUM_REQ);
    localparam int unsigned TO_W  = idw(TIMEOUT + 1);
    localparam int unsigned GP_W  = idw(GAP_CYC + 1);
    localparam int unsigned GAP_N = (GAP_CYC == 0) ? 1 : GAP_CYC;

    arb_state_t             state;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          gidx;
    logic [IW-1:0]          pick_idx;
    logic [NUM_REQ-1:0]     pick_gnt;
    logic [TO_W-1:0]        to_cnt;
    logic [GP_W-1:0]        gap_cnt;
    logic                   last_q;
    logic                   tx_done_q;
    logic                   done_rise;
    logic                   sel_valid;
    logic                   sel_last;
    logic [UART_BYTE_W-1:0] sel_data;
    logic [IW-1:0]          next_ptr;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Only an edge completes a byte; a level left high by UART_tx never does.
    assign done_rise = tx_done & ~tx_done_q;
    assign sel_valid = |(grant & req_valid);
    assign sel_last  = |(grant & req_last);
    assign req_ready = (state == LOAD) ? (grant & req_valid) : '0;
    assign next_ptr  = IW'((32'(gidx) + 32'd1) % NUM_REQ);

    // Owner's byte, selected by the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | req_data[i*UART_BYTE_W +: UART_BYTE_W];
            end
        end
    end

    // Arbiter state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            trmt      <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            abort     <= 1'b0;
            abort_id  <= '0;
            rr_ptr    <= '0;
            gidx      <= '0;
            last_q    <= 1'b0;
            to_cnt    <= '0;
            gap_cnt   <= '0;
            tx_done_q <= 1'b1;
        end else begin
            tx_done_q <= tx_done;
            trmt      <= 1'b0;
            abort     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant  <= pick_gnt;
                        gidx   <= pick_idx;
                        to_cnt <= '0;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    // Accept is checked first so a byte arriving on the last
                    // timeout clock still goes out.
                    if (sel_valid) begin
                        tx_data <= sel_data;
                        last_q  <= sel_last;
                        to_cnt  <= '0;
                        trmt    <= 1'b1;
                        state   <= SEND;
                    end else if (TIMEOUT != 0 && 32'(to_cnt) == TIMEOUT - 1) begin
                        abort    <= 1'b1;
                        abort_id <= gidx;
                        rr_ptr   <= next_ptr;
                        gap_cnt  <= '0;
                        state    <= GAP;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_rise) begin
                        if (last_q) begin
                            rr_ptr  <= next_ptr;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                GAP: begin
                    if (32'(gap_cnt) == GAP_N - 1) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (gap_cnt != '1) begin
                        gap_cnt <= gap_cnt + GP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a byte-source model per requester
// and a UART_tx model whose done level rises 100 clocks after trmt.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned GAP_CYC = 50;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_last = '0;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done = 1'b0;
    logic [1:0]  grant;
    logic        busy;
    logic        abort;
    logic [0:0]  abort_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GAP_CYC (GAP_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .trmt      (trmt),
        .tx_done   (tx_done),
        .grant     (grant),
        .busy      (busy),
        .abort     (abort),
        .abort_id  (abort_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte sources: queue entries are {last, data}
    logic [8:0] srcq0[$];
    logic [8:0] srcq1[$];
    logic [1:0] src_en = '0;
    logic [1:0] acc = '0;

    always @(posedge clk) acc <= req_valid & req_ready;

    always @(negedge clk) begin
        if (acc[0] && srcq0.size() > 0) void'(srcq0.pop_front());
        if (acc[1] && srcq1.size() > 0) void'(srcq1.pop_front());
        if (src_en[0] && srcq0.size() > 0) begin
            req_valid[0] = 1'b1; req_data[7:0] = srcq0[0][7:0]; req_last[0] = srcq0[0][8];
        end else begin
            req_valid[0] = 1'b0; req_last[0] = 1'b0;
        end
        if (src_en[1] && srcq1.size() > 0) begin
            req_valid[1] = 1'b1; req_data[15:8] = srcq1[0][7:0]; req_last[1] = srcq1[0][8];
        end else begin
            req_valid[1] = 1'b0; req_last[1] = 1'b0;
        end
    end

    // UART_tx model
    logic uart_auto = 1'b1;
    int   ucnt = 0;
    int   rise_log[$];

    always @(negedge clk) begin
        if (rst) begin
            ucnt = 0;
            if (uart_auto) tx_done = 1'b0;
        end else if (uart_auto) begin
            if (trmt) begin
                tx_done = 1'b0;
                ucnt = 100;
            end else if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) begin
                    tx_done = 1'b1;
                    rise_log.push_back(cyc);
                end
            end
        end
    end

    // Output monitor
    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  data;
        logic [1:0]  gnt;
    } tx_ev_t;

    tx_ev_t     trmt_log[$];
    int         abort_cyc[$];
    logic [0:0] abort_idl[$];
    int         fall_log[$];
    logic       busy_d = 1'b0;

    always @(negedge clk) begin
        if (trmt === 1'b1) trmt_log.push_back('{cyc, tx_data, grant});
        if (abort === 1'b1) begin
            abort_cyc.push_back(cyc);
            abort_idl.push_back(abort_id);
        end
        if (busy_d === 1'b1 && busy === 1'b0) fall_log.push_back(cyc);
        busy_d = busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        src_en = 2'b00;
        srcq0.delete();
        srcq1.delete();
        rst = 1'b1;
        tick(3);
        trmt_log.delete();
        rise_log.delete();
        abort_cyc.delete();
        abort_idl.delete();
        fall_log.delete();
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_trmts(input int n, input int budget);
        for (int k = 0; k < budget && trmt_log.size() < n; k++) tick();
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && busy !== 1'b0; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        srcq0.push_back(9'h05A);
        src_en = 2'b01;
        tick(3);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b, expected 00", grant); end
        checks++; if (trmt !== 1'b0) begin errors++; $display("FAIL reset_trmt: got %b, expected 0", trmt); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h, expected 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b, expected 0", abort); end
        checks++; if (abort_id !== 1'b0) begin errors++; $display("FAIL reset_abort_id: got %b, expected 0", abort_id); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b, expected 00", req_ready); end
    endtask

    task automatic test_single_frame();
        logic [7:0] exp_b [5];
        int c0;
        exp_b = '{8'hAA, 8'hAA, 8'h55, 8'h01, 8'h23};
        do_reset();
        for (int i = 0; i < 5; i++) srcq0.push_back({(i == 4) ? 1'b1 : 1'b0, exp_b[i]});
        c0 = cyc;
        src_en = 2'b01;
        wait_trmts(5, 1000);
        wait_idle(300);
        checks++; if (trmt_log.size() != 5) begin errors++; $display("FAIL frame_trmt_count: got %0d, expected 5", trmt_log.size()); end
        checks++; if (rise_log.size() != 5) begin errors++; $display("FAIL frame_done_count: got %0d, expected 5", rise_log.size()); end
        if (trmt_log.size() == 5 && rise_log.size() == 5) begin
            // valid appears at cyc c0+1, grant at c0+2, trmt at c0+3
            checks++; if (int'(trmt_log[0].cyc) != c0 + 3) begin errors++; $display("FAIL frame_first_latency: got cyc %0d, expected %0d", trmt_log[0].cyc, c0 + 3); end
            for (int i = 0; i < 5; i++) begin
                checks++; if (trmt_log[i].data !== exp_b[i]) begin errors++; $display("FAIL frame_data[%0d]: got %h, expected %h", i, trmt_log[i].data, exp_b[i]); end
                checks++; if (trmt_log[i].gnt !== 2'b01) begin errors++; $display("FAIL frame_grant[%0d]: got %b, expected 01", i, trmt_log[i].gnt); end
            end
            for (int i = 0; i < 4; i++) begin
                checks++; if (int'(trmt_log[i+1].cyc) - rise_log[i] != 2) begin errors++; $display("FAIL frame_byte_gap[%0d]: got %0d, expected 2", i, int'(trmt_log[i+1].cyc) - rise_log[i]); end
            end
            checks++; if (fall_log.size() != 1 || fall_log[0] != rise_log[4] + int'(GAP_CYC) + 1) begin
                errors++; $display("FAIL frame_busy_fall: got %0d events first %0d, expected one at %0d", fall_log.size(), (fall_log.size() > 0) ? fall_log[0] : -1, rise_log[4] + int'(GAP_CYC) + 1);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [8];
        logic [1:0] exp_g [8];
        exp_d = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
        exp_g = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
        do_reset();
        for (int f = 0; f < 3; f++) begin
            srcq0.push_back({1'b0, 8'(8'h10 + 2 * f)});
            srcq0.push_back({1'b1, 8'(8'h11 + 2 * f)});
            srcq1.push_back({1'b0, 8'(8'h20 + 2 * f)});
            srcq1.push_back({1'b1, 8'(8'h21 + 2 * f)});
        end
        src_en = 2'b11;
        wait_trmts(8, 3000);
        checks++; if (trmt_log.size() < 8) begin errors++; $display("FAIL rr_trmt_count: got %0d, expected at least 8", trmt_log.size()); end
        for (int i = 0; i < 8 && i < trmt_log.size(); i++) begin
            checks++; if (trmt_log[i].data !== exp_d[i]) begin errors++; $display("FAIL rr_data[%0d]: got %h, expected %h", i, trmt_log[i].data, exp_d[i]); end
            checks++; if (trmt_log[i].gnt !== exp_g[i]) begin errors++; $display("FAIL rr_grant[%0d]: got %b, expected %b", i, trmt_log[i].gnt, exp_g[i]); end
        end
    endtask

    task automatic test_gap();
        do_reset();
        srcq1.push_back(9'h031);
        srcq1.push_back(9'h132);
        srcq1.push_back(9'h133);
        src_en = 2'b10;
        wait_trmts(3, 1500);
        checks++; if (trmt_log.size() != 3 || rise_log.size() < 2) begin errors++; $display("FAIL gap_trmt_count: got %0d trmt %0d done, expected 3 trmt", trmt_log.size(), rise_log.size()); end
        if (trmt_log.size() == 3 && rise_log.size() >= 2) begin
            checks++; if (trmt_log[0].gnt !== 2'b10) begin errors++; $display("FAIL gap_grant: got %b, expected 10", trmt_log[0].gnt); end
            checks++; if (int'(trmt_log[1].cyc) - rise_log[0] != 2) begin errors++; $display("FAIL gap_inner: got %0d, expected 2", int'(trmt_log[1].cyc) - rise_log[0]); end
            // GAP_CYC gap clocks, then IDLE, LOAD, SEND
            checks++; if (int'(trmt_log[2].cyc) - rise_log[1] != int'(GAP_CYC) + 3) begin errors++; $display("FAIL gap_frame: got %0d, expected %0d", int'(trmt_log[2].cyc) - rise_log[1], GAP_CYC + 3); end
            checks++; if (trmt_log[2].data !== 8'h33) begin errors++; $display("FAIL gap_data: got %h, expected 33", trmt_log[2].data); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        srcq1.push_back(9'h044);
        src_en = 2'b10;
        wait_trmts(1, 50);
        srcq0.push_back(9'h155);
        src_en = 2'b11;
        for (int k = 0; k < 400 && abort_cyc.size() == 0; k++) tick();
        wait_trmts(2, 400);
        tick(5);
        checks++; if (abort_cyc.size() != 1) begin errors++; $display("FAIL to_abort_pulses: got %0d, expected 1", abort_cyc.size()); end
        checks++; if (trmt_log.size() != 2 || rise_log.size() < 1) begin errors++; $display("FAIL to_trmt_count: got %0d, expected 2", trmt_log.size()); end
        if (abort_cyc.size() == 1 && trmt_log.size() == 2 && rise_log.size() >= 1) begin
            // LOAD occupies rise+1 .. rise+16, abort shows on the first GAP clock
            checks++; if (abort_cyc[0] != rise_log[0] + 17) begin errors++; $display("FAIL to_abort_time: got %0d, expected %0d", abort_cyc[0], rise_log[0] + 17); end
            checks++; if (abort_idl[0] !== 1'b1) begin errors++; $display("FAIL to_abort_id: got %b, expected 1", abort_idl[0]); end
            checks++; if (trmt_log[1].gnt !== 2'b01) begin errors++; $display("FAIL to_next_grant: got %b, expected 01", trmt_log[1].gnt); end
            checks++; if (trmt_log[1].data !== 8'h55) begin errors++; $display("FAIL to_next_data: got %h, expected 55", trmt_log[1].data); end
            checks++; if (int'(trmt_log[1].cyc) != abort_cyc[0] + int'(GAP_CYC) + 2) begin errors++; $display("FAIL to_next_time: got %0d, expected %0d", trmt_log[1].cyc, abort_cyc[0] + int'(GAP_CYC) + 2); end
        end
    endtask

    task automatic test_stale_done();
        int n;
        uart_auto = 1'b0;
        tx_done = 1'b1;
        do_reset();
        srcq0.push_back(9'h066);
        srcq0.push_back(9'h167);
        src_en = 2'b01;
        wait_trmts(1, 50);
        tick(300);
        checks++; if (trmt_log.size() != 1) begin errors++; $display("FAIL stale_trmt_count: got %0d, expected 1", trmt_log.size()); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stale_busy: got %b, expected 1", busy); end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL stale_grant: got %b, expected 01", grant); end
        tx_done = 1'b0;
        tick();
        tx_done = 1'b1;
        n = cyc;
        wait_trmts(2, 20);
        checks++; if (trmt_log.size() != 2) begin errors++; $display("FAIL stale_resume_count: got %0d, expected 2", trmt_log.size()); end
        if (trmt_log.size() == 2) begin
            checks++; if (int'(trmt_log[1].cyc) != n + 2) begin errors++; $display("FAIL stale_resume_time: got %0d, expected %0d", trmt_log[1].cyc, n + 2); end
            checks++; if (trmt_log[1].data !== 8'h67) begin errors++; $display("FAIL stale_resume_data: got %h, expected 67", trmt_log[1].data); end
        end
        tx_done = 1'b0;
        tick();
        tx_done = 1'b1;
        wait_idle(100);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stale_idle: got busy %b, expected 0", busy); end
        uart_auto = 1'b1;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        srcq0.push_back(9'h170);
        src_en = 2'b01;
        wait_trmts(1, 50);
        wait_idle(300);
        for (int i = 0; i < 5; i++) srcq1.push_back({(i == 4) ? 1'b1 : 1'b0, 8'(8'h81 + i)});
        src_en = 2'b11;
        wait_trmts(4, 600);
        tick(10);
        checks++; if (busy !== 1'b1 || trmt_log.size() != 4) begin errors++; $display("FAIL mid_precond: got busy %b trmt %0d, expected 1 and 4", busy, trmt_log.size()); end
        src_en = 2'b00;
        srcq0.delete();
        srcq1.delete();
        rst = 1'b1;
        tick();
        checks++; if (trmt !== 1'b0) begin errors++; $display("FAIL mid_trmt: got %b, expected 0", trmt); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL mid_grant: got %b, expected 00", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, expected 0", busy); end
        rst = 1'b0;
        trmt_log.delete();
        rise_log.delete();
        srcq0.push_back(9'h190);
        srcq1.push_back(9'h191);
        src_en = 2'b11;
        wait_trmts(1, 100);
        checks++; if (trmt_log.size() != 1) begin errors++; $display("FAIL mid_restart_count: got %0d, expected 1", trmt_log.size()); end
        if (trmt_log.size() == 1) begin
            checks++; if (trmt_log[0].gnt !== 2'b01) begin errors++; $display("FAIL mid_restart_grant: got %b, expected 01", trmt_log[0].gnt); end
            checks++; if (trmt_log[0].data !== 8'h90) begin errors++; $display("FAIL mid_restart_data: got %h, expected 90", trmt_log[0].data); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_gap();
        test_timeout();
        test_stale_done();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART_tx transmitter among NUM_REQ byte-stream requesters, such as the telemetry packetiser and a fault/debug reporter.
- Arbitration is round-robin at frame granularity. Once a requester is granted, all bytes of its frame go out back-to-back with no interleaving.
- Drives tx_data/trmt into UART_tx and consumes its tx_done.
- Enforces a minimum inter-frame gap and aborts frames whose source stalls mid-frame.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- GAP_CYC, 0, minimum idle clocks between frames; the effective gap is max(GAP_CYC,1).
- TIMEOUT, 1024, max clocks waiting for the next byte of a granted frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  reset, synchronous, active-high; shared with UART_tx.
- req_valid  in  NUM_REQ  requester i has a byte on req_data.
- req_data  in  8*NUM_REQ  requester i byte at [8i+7:8i].
- req_last  in  NUM_REQ  the presented byte is the last of its frame.
- req_ready  out  NUM_REQ  byte accepted when req_valid[i]&req_ready[i].
- tx_data  out  8  byte to UART_tx, stable from trmt until tx_done.
- trmt  out  1  one-clock start pulse to UART_tx.
- tx_done  in  1  UART_tx done level; cleared by UART_tx on trmt.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- busy  out  1  high in any state except IDLE.
- abort  out  1  one-clock pulse when a frame times out.
- abort_id  out  max(1,clog2(NUM_REQ))  index of the aborted requester; valid with abort.

Behaviour:
- Reset values: state=IDLE, grant=0, trmt=0, tx_data=0, req_ready=0, busy=0, abort=0, abort_id=0, rr_ptr=0. tx_done_q resets to 1, so a stale-high tx_done cannot fake an edge.
- Completion event is done_rise = tx_done & ~tx_done_q, with tx_done_q registered every clock. A level-high tx_done alone never completes a byte.
- IDLE: if any req_valid, pick the first set bit scanning from rr_ptr upward with wrap. Register grant and go to LOAD. Otherwise stay.
- LOAD:
  - req_ready[g] = req_valid[g] (combinational); all other ready bits are 0.
  - On accept: latch tx_data<=req_data[g] and last_q<=req_last[g], clear the timeout counter, go to SEND.
  - No valid: increment the timeout counter. When it reaches TIMEOUT (nonzero): pulse abort, set abort_id=g, go to GAP.
- SEND: trmt=1 for exactly this one clock, then go to WAIT.
- WAIT: hold tx_data.
  - On done_rise with last_q=1: go to GAP.
  - On done_rise with last_q=0: go to LOAD.
  - No timeout is applied in WAIT.
- GAP: entered from WAIT on the last byte, or from LOAD on abort.
  - On entry, rr_ptr<=(g+1) mod NUM_REQ.
  - grant stays asserted during GAP.
  - Count max(GAP_CYC,1) clocks, then clear grant and go to IDLE.
- Latency: req_valid rising in IDLE at clock 0 gives grant and ready at clock 1, then trmt at clock 2. Between bytes there are 2 clocks from done_rise to the next trmt (LOAD, SEND) when the next byte is already valid.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- A requester deasserting valid in IDLE is not latched as a request; a request is never sticky.
- Boundaries:
  - A single-byte frame (last=1 on the first byte) is legal.
  - req_valid/req_data changes of non-granted requesters are ignored.
  - Simultaneous abort-timeout and valid in the same LOAD clock: the accept wins and no abort is raised.
  - rst asserted mid-frame: next clock everything returns to reset values. A UART byte in flight is discarded by UART_tx's own reset.
- Width rules:
  - Timeout counter width is clog2(TIMEOUT+1).
  - Gap counter width is clog2(GAP_CYC+1), minimum 1.
  - Both counters saturate and never wrap.

Decomposition:
- Shared package eb_uart_pkg holds:
  - arb_state_t enum {IDLE, LOAD, SEND, WAIT, GAP};
  - localparam UART_BYTE_W=8;
  - an IDW helper function.
- One sub-module: rr_pick (combinational). Inputs are req[NUM_REQ] and ptr; outputs are one-hot gnt and an index. It is reusable by other shared-resource arbiters.

Test Plan:
1. Requester 0 sends frame AA,AA,55,01,23 (last on 23) with an ideal UART model (tx_done rises 100 clocks after trmt) -> exactly 5 trmt pulses, tx_data sequence matches, grant=01 throughout, busy falls after the gap.
2. Both requesters hold 2-byte frames continuously valid from reset -> frames granted 0,1,0,1; bytes are never interleaved within a frame; rr_ptr alternates.
3. GAP_CYC=50 with back-to-back frames from requester 1 only -> at least 50 clocks from the final done_rise of frame 1 to the first trmt of frame 2 (≥ GAP_CYC+2).
4. TIMEOUT=16: requester 1 sends one byte without last, then drops valid -> abort pulses for 1 clock 16 clocks into LOAD with abort_id=1; requester 0 is granted next.
5. tx_done held high from reset and never toggles -> no byte completes; the arbiter stays in WAIT after the first trmt. After tx_done falls and rises, it proceeds.
6. rst asserted for 1 clock during WAIT of byte 3 -> next clock: trmt=0, grant=0, busy=0, rr_ptr=0; a new frame afterwards starts cleanly from requester 0.
